// File: rtl/usb4_enc_pkg.sv
// Shared definitions for the USB4 lane encode/transmit path: speed encodings,
// symbol lengths, sync headers and the gearbox FSM state type.
package usb4_enc_pkg;

    typedef enum logic [1:0] {
        GEN4_BYTE = 2'd0,
        GEN3      = 2'd1,
        GEN2      = 2'd2,
        GEN_RSVD  = 2'd3
    } gen_speed_e;

    localparam int unsigned SYM_W = 132;

    localparam logic [7:0] LEN_GEN4 = 8'd8;
    localparam logic [7:0] LEN_GEN3 = 8'd132;
    localparam logic [7:0] LEN_GEN2 = 8'd66;

    localparam logic [3:0] SYNC_GEN3_A = 4'b0101;
    localparam logic [3:0] SYNC_GEN3_B = 4'b1010;
    localparam logic [1:0] SYNC_GEN2_A = 2'b01;
    localparam logic [1:0] SYNC_GEN2_B = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } tx_state_e;

    // Encoded symbol length in bits for a gen_speed value (reserved maps to 8).
    function automatic logic [7:0] sym_len(input logic [1:0] spd);
        case (spd)
            GEN4_BYTE: sym_len = LEN_GEN4;
            GEN3:      sym_len = LEN_GEN3;
            GEN2:      sym_len = LEN_GEN2;
            default:   sym_len = LEN_GEN4;
        endcase
    endfunction

endpackage

// File: rtl/usb4_bit_accum.sv
// Bit buffer for the transmit gearbox: holds buffered bits LSB-first (oldest
// at bit 0), shifts out one OUT_W word on drain and inserts a new symbol at
// the post-drain fill position in the same cycle.
module usb4_bit_accum
    import usb4_enc_pkg::*;
#(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned BUF_W = 264,
    parameter int unsigned SYM_IN_W = 132,
    parameter int unsigned CNT_W = 9
) (
    input  logic                i_enc_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_drain,
    input  logic                i_load,
    input  logic [7:0]          i_len,
    input  logic [SYM_IN_W-1:0] i_sym,
    output logic [OUT_W-1:0]    o_word,
    output logic [CNT_W-1:0]    o_cnt
);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_cnt;
    logic [BUF_W-1:0] w_shifted;
    logic [BUF_W-1:0] w_mask;
    logic [BUF_W-1:0] w_ins;
    logic [BUF_W-1:0] w_buf_nxt;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next buffer: optional right shift by OUT_W, then OR the length-masked
    // symbol in at the post-drain fill count. Bits above cnt are always zero.
    always_comb begin
        w_shifted = i_drain ? (r_buf >> OUT_W) : r_buf;
        w_base    = i_drain ? (r_cnt - CNT_W'(OUT_W)) : r_cnt;
        w_mask    = ~({BUF_W{1'b1}} << i_len);
        w_ins     = (BUF_W'(i_sym) & w_mask) << w_base;
        w_buf_nxt = w_shifted;
        w_cnt_nxt = w_base;
        if (i_load) begin
            w_buf_nxt = w_shifted | w_ins;
            w_cnt_nxt = w_base + CNT_W'(i_len);
        end
    end

    // Buffer and fill-count registers; clear has priority over load/drain.
    always_ff @(posedge i_enc_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_word = r_buf[OUT_W-1:0];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/usb4_tx_gearbox.sv
// Per-lane transmit gearbox: packs 8/132/66-bit encoded symbols LSB-first and
// emits fixed OUT_W-bit words. Holds the lane FSM and sticky status flags.
module usb4_tx_gearbox
    import usb4_enc_pkg::*;
#(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned BUF_W = 264
) (
    input  logic             enc_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       gen_speed,
    input  logic [131:0]     sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             overflow,
    output logic             fault
);

    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [1:0]         r_spd;
    logic [OUT_W-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_overflow;
    logic               r_fault;
    logic [CNT_W-1:0]   w_cnt;
    logic [OUT_W-1:0]   w_word;
    logic               w_run;
    logic               w_drain;
    logic               w_load;
    logic               w_clear;
    logic [7:0]         w_len;
    logic [CNT_W:0]     w_after;

    // Next-state logic: enable low forces IDLE from anywhere; FAULT is exited only that way.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = (gen_speed == GEN_RSVD) ? ST_FAULT : ST_ACTIVE;
                ST_ACTIVE: if (gen_speed != r_spd) w_state_nxt = ST_FAULT;
                ST_FAULT:  w_state_nxt = ST_FAULT;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath control: drain/accept only while ACTIVE with a stable speed, so
    // a speed change or enable drop produces no word and accepts no symbol.
    always_comb begin
        w_run     = (r_state == ST_ACTIVE) && enable && (gen_speed == r_spd);
        w_len     = sym_len(r_spd);
        w_drain   = w_run && (w_cnt >= CNT_W'(OUT_W));
        w_after   = {1'b0, w_cnt} - (w_drain ? (CNT_W+1)'(OUT_W) : '0);
        sym_ready = w_run && ((w_after + (CNT_W+1)'(w_len)) <= (CNT_W+1)'(BUF_W));
        w_load    = sym_valid && sym_ready;
        w_clear   = (w_state_nxt != ST_ACTIVE);
    end

    // State register; the speed is captured on the IDLE -> ACTIVE transition.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_spd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_ACTIVE) begin
                r_spd <= gen_speed;
            end
        end
    end

    // Output word register and sticky overflow/fault flags (cleared by enable low).
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_dout_valid <= w_drain;
            if (w_drain) begin
                r_dout <= w_word;
            end
            if (!enable) begin
                r_overflow <= 1'b0;
                r_fault    <= 1'b0;
            end else begin
                if (w_run && sym_valid && !sym_ready) begin
                    r_overflow <= 1'b1;
                end
                if (w_state_nxt == ST_FAULT && r_state != ST_FAULT) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    usb4_bit_accum #(
        .OUT_W    (OUT_W),
        .BUF_W    (BUF_W),
        .SYM_IN_W (SYM_W),
        .CNT_W    (CNT_W)
    ) u_accum (
        .i_enc_clk (enc_clk),
        .i_rst     (rst),
        .i_clear   (w_clear),
        .i_drain   (w_drain),
        .i_load    (w_load),
        .i_len     (w_len),
        .i_sym     (sym_in),
        .o_word    (w_word),
        .o_cnt     (w_cnt)
    );

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overflow   = r_overflow;
    assign fault      = r_fault;

endmodule

// File: tb/tb_usb4_tx_gearbox.sv
// Directed bench for usb4_tx_gearbox (OUT_W = 16): expected words are built
// from an LSB-first bit queue when symbols are driven and checked by a monitor.
module tb_usb4_tx_gearbox;
    import usb4_enc_pkg::*;

    localparam int unsigned OUT_W = 16;

    logic             enc_clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [1:0]       gen_speed;
    logic [131:0]     sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             overflow;
    logic             fault;

    int errors = 0;
    int checks = 0;
    int n_words = 0;

    bit               bq[$];
    logic [OUT_W-1:0] exp_q[$];

    usb4_tx_gearbox #(.OUT_W(OUT_W), .BUF_W(264)) dut (
        .enc_clk    (enc_clk),
        .rst        (rst),
        .enable     (enable),
        .gen_speed  (gen_speed),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overflow   (overflow),
        .fault      (fault)
    );

    always #5 enc_clk = ~enc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge enc_clk);
        #2;
    endtask

    // Append a symbol's bits to the stream and queue every completed word.
    task automatic push_sym(input logic [131:0] s, input int unsigned len);
        logic [OUT_W-1:0] w;
        for (int unsigned i = 0; i < len; i++) bq.push_back(s[i]);
        while (bq.size() >= OUT_W) begin
            for (int unsigned j = 0; j < OUT_W; j++) w[j] = bq.pop_front();
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [131:0] rnd132();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[131:0];
    endfunction

    task automatic start(input logic [1:0] spd);
        sym_valid = 1'b0;
        enable    = 1'b0;
        tick();
        bq.delete();
        exp_q.delete();
        gen_speed = spd;
        enable    = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string tag, input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every valid word must match the head of the queue.
    always @(negedge enc_clk) begin
        if (dout_valid) begin
            logic [OUT_W-1:0] e;
            n_words++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed=%0h expected=<none>", dout);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout_word", dout, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [131:0] s;

        rst = 1'b0; enable = 1'b0; gen_speed = GEN2; sym_in = '0; sym_valid = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_fault", fault, 0);
        chk("rst_sym_ready", sym_ready, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("idle_cnt", dut.w_cnt, 0);

        // Gen2 single symbol: four words then a 2-bit tail.
        start(GEN2);
        sym_in = '0;
        sym_in[65:0] = 66'h2_0123_4567_89AB_CDEF;
        sym_valid = 1'b1;
        #1 chk("g2_ready", sym_ready, 1);
        push_sym(sym_in, 66);
        tick();
        sym_valid = 1'b0;
        tick(); chk("g2_v0", dout_valid, 1); chk("g2_w0", dout, 16'hCDEF);
        tick(); chk("g2_v1", dout_valid, 1); chk("g2_w1", dout, 16'h89AB);
        tick(); chk("g2_v2", dout_valid, 1); chk("g2_w2", dout, 16'h4567);
        tick(); chk("g2_v3", dout_valid, 1); chk("g2_w3", dout, 16'h0123);
        tick(); chk("g2_v4", dout_valid, 0);
        chk("g2_cnt", dut.w_cnt, 2);
        chk("g2_tail", dut.u_accum.r_buf[1:0], 2'b10);
        chk("g2_sb_empty", exp_q.size(), 0);

        // Gen3: 8 symbols, one every 17 cycles.
        start(GEN3);
        n_words = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            s = rnd132();
            s[3:0] = (k % 2 == 0) ? SYNC_GEN3_A : SYNC_GEN3_B;
            sym_in = s;
            sym_valid = 1'b1;
            #1 chk("g3_ready", sym_ready, 1);
            push_sym(s, 132);
            tick();
            sym_valid = 1'b0;
            repeat (16) tick();
        end
        wait_drain("g3_drain", 20);
        chk("g3_words", n_words, 66);
        chk("g3_overflow", overflow, 0);
        chk("g3_cnt", dut.w_cnt, 0);

        // Gen4 byte mode: garbage above bit 7 must be ignored.
        start(GEN4_BYTE);
        for (int unsigned k = 0; k < 4; k++) begin
            s = rnd132();
            s[7:0] = 8'(k + 1);
            sym_in = s;
            sym_valid = 1'b1;
            push_sym(s, 8);
            if (k == 3) begin
                chk("g4_v_a", dout_valid, 1);
                chk("g4_w_a", dout, 16'h0201);
            end
            tick();
        end
        sym_valid = 1'b0;
        chk("g4_v_b", dout_valid, 0);
        tick();
        chk("g4_v_c", dout_valid, 1);
        chk("g4_w_c", dout, 16'h0403);
        tick();
        chk("g4_sb_empty", exp_q.size(), 0);

        // Overflow: Gen3 with sym_valid held; third symbol cannot fit.
        start(GEN3);
        s = rnd132(); s[3:0] = SYNC_GEN3_A;
        sym_in = s; sym_valid = 1'b1;
        #1 chk("ov_ready0", sym_ready, 1);
        push_sym(s, 132);
        tick();
        s = rnd132(); s[3:0] = SYNC_GEN3_B;
        sym_in = s;
        #1 chk("ov_ready1", sym_ready, 1);
        push_sym(s, 132);
        tick();
        sym_in = rnd132();
        #1 chk("ov_ready2", sym_ready, 0);
        tick();
        chk("ov_flag", overflow, 1);
        sym_valid = 1'b0;
        wait_drain("ov_drain", 30);
        tick();
        chk("ov_cnt", dut.w_cnt, 8);
        chk("ov_sticky", overflow, 1);
        enable = 1'b0;
        tick();
        chk("ov_clear", overflow, 0);
        chk("ov_flush", dut.w_cnt, 0);

        // Speed change while ACTIVE with cnt = 34.
        start(GEN2);
        s = rnd132(); s[1:0] = SYNC_GEN2_A;
        sym_in = s; sym_valid = 1'b1;
        push_sym(s, 66);
        tick();
        sym_valid = 1'b0;
        tick(); tick();
        chk("sc_cnt", dut.w_cnt, 34);
        gen_speed = GEN3;
        tick();
        chk("sc_state", dut.r_state, ST_FAULT);
        chk("sc_fault", fault, 1);
        chk("sc_dout_valid", dout_valid, 0);
        chk("sc_ready", sym_ready, 0);
        chk("sc_pending", exp_q.size(), 2);
        exp_q.delete(); bq.delete();
        gen_speed = GEN2;
        tick(); tick();
        chk("sc_fault_hold", fault, 1);
        chk("sc_dv_hold", dout_valid, 0);
        enable = 1'b0;
        tick();
        chk("sc_fault_clr", fault, 0);

        // Reserved speed on entry.
        gen_speed = GEN_RSVD; enable = 1'b1;
        tick();
        chk("rs_fault", fault, 1);
        chk("rs_ready", sym_ready, 0);

        // Asynchronous reset mid-stream at cnt = 100.
        start(GEN2);
        s = rnd132(); s[1:0] = SYNC_GEN2_B;
        sym_in = s; sym_valid = 1'b1;
        push_sym(s, 66);
        tick();
        s = rnd132(); s[1:0] = SYNC_GEN2_A;
        sym_in = s;
        #1 chk("rr_ready", sym_ready, 1);
        push_sym(s, 66);
        tick();
        sym_valid = 1'b0;
        tick();
        chk("rr_cnt", dut.w_cnt, 100);
        rst = 1'b0;
        #1;
        chk("rr_dout", dout, 0);
        chk("rr_dout_valid", dout_valid, 0);
        chk("rr_cnt0", dut.w_cnt, 0);
        exp_q.delete(); bq.delete();
        tick();
        rst = 1'b1;
        tick();
        s = rnd132(); s[1:0] = SYNC_GEN2_B;
        sym_in = s; sym_valid = 1'b1;
        #1 chk("rr_ready2", sym_ready, 1);
        push_sym(s, 66);
        tick();
        sym_valid = 1'b0;
        wait_drain("rr_drain", 10);
        chk("rr_tail_cnt", dut.w_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
